fpaddsub_issue_ctrl: RTL and testbench
======================================

# fpaddsub_issue_ctrl

Issue and result-collection controller placed directly around the 11-stage pipelined FP adder/subtractor. It accepts operand pairs over a valid/ready handshake, registers them onto the adder inputs, and tracks every in-flight operation with a valid/tag shift register aligned to the adder latency. Results are captured into a credit-protected result FIFO, so the non-stallable adder never drops a result under output back-pressure.

## Interface
- LAT, 11: cycles from operand present on add_a/add_b/add_ctrl to matching result on add_z/add_flags.
- DEPTH, 16: result FIFO entries; power of two, must be >= 2.
- TAG_W, 4: width of the user tag carried alongside each operation.

- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair this cycle.
- in_a, in_b  in  32 each  IEEE754 single operands.
- in_sub  in  1  0 = add, 1 = subtract.
- in_tag  in  TAG_W  user tag, returned with the result.
- add_a, add_b  out  32 each  registered operands to the adder.
- add_ctrl  out  1  registered op to the adder's Ctrl.
- add_rst  out  1  active-high reset to the adder.
- add_z  in  32  adder result.
- add_flags  in  5  adder flags: [4] overflow, [3] underflow, [2] div-by-zero, [1] invalid, [0] inexact.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_z  out  32  result.
- out_flags  out  5  result flags.
- out_tag  out  TAG_W  tag of the result.
- sticky_flags  out  5  OR of out_flags over all popped results since reset or clear.
- sticky_clr  in  1  synchronous clear of sticky_flags.

## Operation
- Fire = in_valid & in_ready. On fire in cycle c, register in_a/in_b/in_sub onto add_a/add_b/add_ctrl for cycle c+1. Load {1, in_tag} into stage 0 of a LAT-deep valid/tag shift register.
- On non-fire cycles, drive add_a = add_b = 0 and add_ctrl = 0 (bubble). Load stage 0 with valid = 0.
- When the shift register tail is valid in cycle c+1+LAT, write {add_z, add_flags, tail tag} into the FIFO at the end of that cycle. The write is unconditional. Credit guarantees space.
- inflight counter, width log2(DEPTH)+1: increment on fire, decrement on tail-valid write. If both occur in the same cycle, the counter is unchanged.
- count = FIFO occupancy: increment on write, decrement on pop (out_valid & out_ready). If both occur in the same cycle, count is unchanged.
- in_ready = !add_rst & (count + inflight < DEPTH). It is combinational from registered state only, with no dependency on in_valid or out_ready.
- out_valid = (count != 0). out_z, out_flags and out_tag show the head entry, read from the registered head.
- Results leave strictly in issue order.
- Pops while empty and pushes while full cannot occur. The bench asserts that the FIFO never overflows.
- sticky_flags |= out_flags on each pop. If sticky_clr is high in the same cycle as a pop, the result is exactly the popped flags.

## Timing
- Reset while rst = 0: in_ready 0, out_valid 0, out_z / out_flags / out_tag 0, add_a / add_b / add_ctrl 0, sticky_flags 0, add_rst 1. All counters, pointers and shift-register valids are cleared asynchronously.
- add_rst asserts asynchronously with rst. It deasserts on the 2nd rising edge after rst rises, via a 2-flop synchronizer. in_ready stays 0 until add_rst is 0.
- Stale adder contents are harmless: the shift-register valids are 0 after reset.
- Latency: fire in cycle c, add_* valid in c+1, add_z valid in c+1+LAT (c+12), FIFO write at the end of c+12, out_valid in c+13 if the FIFO was empty. Minimum in-to-out latency is LAT+2 = 13 cycles.
- Throughput: one fire per cycle sustained while out_ready = 1. Steady state requires DEPTH >= LAT+2 for full rate. With DEPTH = 16, full rate is sustained.
- Reset asserted mid-operation discards all in-flight and queued results. No result from before reset is ever presented after reset.

## Test plan
- Single op: in_a = 0x3F800000, in_b = 0x40000000, in_sub = 0, tag 5, fired at cycle c -> out_valid first high at c+13, out_z = 0x40400000, out_flags bit0 = 0, out_tag = 5.
- Subtract to zero: 0x40400000 - 0x40400000 -> out_z = 0x00000000, flags = 0.
- Back-pressure: out_ready = 0, in_valid held high with tags 0..19 -> exactly 16 fires, then in_ready = 0. Raise out_ready -> tags 0..15 pop in order, then the remaining 4 are accepted and returned. No loss and no duplication.
- Invalid: +inf (0x7F800000) - +inf -> out_flags[1] = 1, sticky_flags[1] = 1 after pop. Pulse sticky_clr with no pop -> sticky_flags = 0.
- Reset mid-flight: issue 6 ops, drop rst 4 cycles later for 1 cycle -> all outputs are 0 immediately. in_ready returns 2 edges after release, and no old result ever appears.
- Full rate: 100 random ops with out_ready = 1 -> in_ready never drops, and results match the reference model in order.

Source files
------------

// File: rtl/fpaddsub_issue_ctrl.sv
// fpaddsub_issue_ctrl
//
// Issue / result-collection wrapper around an LAT-stage, non-stallable,
// pipelined FP adder/subtractor. Operands arrive over a valid/ready
// handshake and are registered onto the adder inputs. A valid/tag shift
// register follows each operation through the adder. Completed results land
// in a result FIFO, and every slot in that FIFO is reserved by a credit check
// before issue. Because of this, back-pressure on the output can never cause
// a result to be dropped.
//
// Ports
//   clk            single clock, rising edge
//   rst            asynchronous, active-low reset
//   in_valid/in_ready, in_a, in_b, in_sub, in_tag
//                  operand handshake (in_sub: 0 = add, 1 = subtract)
//   add_a, add_b, add_ctrl
//                  registered operands/op to the adder (zero on bubbles)
//   add_rst        active-high adder reset, released two edges after rst
//   add_z, add_flags
//                  adder result, LAT cycles after the operands
//   out_valid/out_ready, out_z, out_flags, out_tag
//                  result handshake, issue order
//   sticky_flags   OR of popped out_flags since reset or sticky_clr
//   sticky_clr     synchronous clear of sticky_flags
module fpaddsub_issue_ctrl #(
   parameter int LAT   = 11,
   parameter int DEPTH = 16,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic             in_sub,
   input  logic [TAG_W-1:0] in_tag,
   output logic [31:0]      add_a,
   output logic [31:0]      add_b,
   output logic             add_ctrl,
   output logic             add_rst,
   input  logic [31:0]      add_z,
   input  logic [4:0]       add_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_z,
   output logic [4:0]       out_flags,
   output logic [TAG_W-1:0] out_tag,
   output logic [4:0]       sticky_flags,
   input  logic             sticky_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 32 + 5 + TAG_W;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   // reset release synchronizer for the adder and the issue gate
   logic [1:0] rst_sync_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rst_sync_q <= 2'b00;
      else      rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   assign add_rst = ~rst_sync_q[1];

   // credit-based issue gate
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW:0]   credit_used;
   logic          fire;
   logic          wr_en;
   logic          pop;

   assign credit_used = {1'b0, count_q} + {1'b0, inflight_q};
   assign in_ready    = ~add_rst & (credit_used < DEPTH_C);
   assign fire        = in_valid & in_ready;

   // operand registers; bubbles drive zeros
   logic [31:0] add_a_q, add_a_d;
   logic [31:0] add_b_q, add_b_d;
   logic        add_ctrl_q, add_ctrl_d;

   always_comb begin
      add_a_d    = '0;
      add_b_d    = '0;
      add_ctrl_d = 1'b0;
      if (fire) begin
         add_a_d    = in_a;
         add_b_d    = in_b;
         add_ctrl_d = in_sub;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         add_a_q    <= '0;
         add_b_q    <= '0;
         add_ctrl_q <= 1'b0;
      end else begin
         add_a_q    <= add_a_d;
         add_b_q    <= add_b_d;
         add_ctrl_q <= add_ctrl_d;
      end
   end

   assign add_a    = add_a_q;
   assign add_b    = add_b_q;
   assign add_ctrl = add_ctrl_q;

   // Stage 0 is aligned with the operands sitting on add_a/add_b. After LAT
   // more shifts, stage LAT is aligned with the matching add_z.
   logic [LAT:0]     vld_q;
   logic [TAG_W-1:0] tag_q [LAT+1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) vld_q <= '0;
      else      vld_q <= {vld_q[LAT-1:0], fire};
   end

   // tags are qualified by vld_q, so they need no reset
   always_ff @(posedge clk) begin
      tag_q[0] <= in_tag;
      for (int i = 1; i <= LAT; i++) tag_q[i] <= tag_q[i-1];
   end

   // result FIFO
   logic [EW-1:0]   mem [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [4:0]      sticky_q, sticky_d;
   logic [EW-1:0]   head;

   assign wr_en     = vld_q[LAT];
   assign out_valid = (count_q != '0);
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= {add_z, add_flags, tag_q[LAT]};
   end

   always_comb begin
      count_d = count_q;
      case ({wr_en, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      inflight_d = inflight_q;
      case ({fire, wr_en})
         2'b10:   inflight_d = inflight_q + CW'(1);
         2'b01:   inflight_d = inflight_q - CW'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         inflight_q <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q    <= count_d;
         inflight_q <= inflight_d;
      end
   end

   // Gating the head with out_valid keeps the outputs at zero when the FIFO is
   // empty, and it hides the unreset storage.
   assign head      = out_valid ? mem[rd_ptr_q] : '0;
   assign out_z     = head[EW-1 -: 32];
   assign out_flags = head[TAG_W +: 5];
   assign out_tag   = head[TAG_W-1:0];

   // when sticky_clr is set, only the flags popped in this cycle survive
   always_comb begin
      sticky_d = sticky_clr ? 5'b0 : sticky_q;
      if (pop) sticky_d = sticky_d | out_flags;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sticky_q <= '0;
      else      sticky_q <= sticky_d;
   end

   assign sticky_flags = sticky_q;

endmodule

// File: tb/tb_fpaddsub_issue_ctrl.sv
module tb_fpaddsub_issue_ctrl;

   localparam int LAT   = 11;
   localparam int DEPTH = 16;
   localparam int TAG_W = 4;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_a, in_b;
   logic             in_sub;
   logic [TAG_W-1:0] in_tag;
   logic [31:0]      add_a, add_b;
   logic             add_ctrl;
   logic             add_rst;
   logic [31:0]      add_z;
   logic [4:0]       add_flags;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_z;
   logic [4:0]       out_flags;
   logic [TAG_W-1:0] out_tag;
   logic [4:0]       sticky_flags;
   logic             sticky_clr;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   fpaddsub_issue_ctrl #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
      .add_a(add_a), .add_b(add_b), .add_ctrl(add_ctrl), .add_rst(add_rst),
      .add_z(add_z), .add_flags(add_flags),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_z(out_z), .out_flags(out_flags), .out_tag(out_tag),
      .sticky_flags(sticky_flags), .sticky_clr(sticky_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Adder stand-in. The controller only transports words, so the stub returns
   // real IEEE results for the hand-picked cases and a cheap operand hash
   // everywhere else.
   function automatic logic [36:0] fp_model(logic [31:0] a, logic [31:0] b, logic sub);
      logic [31:0] z;
      if (a == 32'h3F800000 && b == 32'h40000000 && !sub) return {32'h40400000, 5'b00000};
      if (a == 32'h40000000 && b == 32'h40000000 && !sub) return {32'h40800000, 5'b00000};
      if (a == 32'h40400000 && b == 32'h40400000 &&  sub) return {32'h00000000, 5'b00000};
      if (a == 32'h7F800000 && b == 32'h7F800000 &&  sub) return {32'h7FC00000, 5'b00010};
      z = a ^ {b[15:0], b[31:16]} ^ {31'd0, sub};
      return {z, z[4:0]};
   endfunction

   logic [36:0] pipe [LAT];
   always @(posedge clk) begin
      pipe[0] <= fp_model(add_a, add_b, add_ctrl);
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign add_z     = pipe[LAT-1][36:5];
   assign add_flags = pipe[LAT-1][4:0];

   typedef struct {
      logic [31:0]      a;
      logic [31:0]      b;
      logic             sub;
      logic [TAG_W-1:0] tag;
      logic [31:0]      exp_z;
      logic [4:0]       exp_flags;
   } vec_t;

   vec_t vecs[4];
   logic [40:0] sb[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 100) begin step(); n++; end
   endtask

   // one op with out_ready low; returns cycles from fire to first out_valid
   task automatic issue_wait(input logic [31:0] a, input logic [31:0] b, input logic sub,
                             input logic [TAG_W-1:0] tag, output int lat);
      int c;
      int n;
      wait_ready();
      in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_tag = tag;
      c = cyc;
      step();
      in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_tag = '0;
      n = 0;
      while (!out_valid && n < 60) begin step(); n++; end
      lat = cyc - c;
   endtask

   task automatic pop_one(input logic clr);
      out_ready = 1'b1; sticky_clr = clr;
      step();
      out_ready = 1'b0; sticky_clr = 1'b0;
   endtask

   initial begin
      int lat;
      int idx;
      int fires;
      int pops;
      int drops;
      int n;
      logic fired;
      logic [36:0] r;

      vecs[0] = '{32'h3F800000, 32'h40000000, 1'b0, 4'd5,  32'h40400000, 5'b00000};
      vecs[1] = '{32'h40400000, 32'h40400000, 1'b1, 4'd3,  32'h00000000, 5'b00000};
      vecs[2] = '{32'h7F800000, 32'h7F800000, 1'b1, 4'd9,  32'h7FC00000, 5'b00010};
      vecs[3] = '{32'h40000000, 32'h40000000, 1'b0, 4'd12, 32'h40800000, 5'b00000};

      rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_tag = '0;
      out_ready = 1'b0; sticky_clr = 1'b0;

      // scoreboard and overflow monitor; sampled on the falling edge
      fork
         forever begin
            @(negedge clk);
            if (!rst) sb.delete();
            else begin
               if (in_valid && in_ready) sb.push_back({fp_model(in_a, in_b, in_sub), in_tag});
               if (out_valid && out_ready) begin
                  if (sb.size() == 0) chk("result_unexpected", 64'({out_z, out_flags, out_tag}), 64'h0 - 1);
                  else chk("result_order", 64'({out_z, out_flags, out_tag}), 64'(sb.pop_front()));
               end
               if (dut.vld_q[LAT] && dut.count_q == DEPTH) chk("fifo_overflow", 64'(dut.count_q), 64'(DEPTH - 1));
            end
         end
      join_none

      #1; step(); step();
      chk("rst_in_ready",  64'(in_ready), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_outputs",   64'({out_z, out_flags, out_tag, sticky_flags}), 64'(0));
      chk("rst_add_ops",   64'({add_a, add_b, add_ctrl}), 64'(0));
      chk("rst_add_rst",   64'(add_rst), 64'(1));

      #2 rst = 1'b1;
      step();
      chk("release_edge1_in_ready", 64'({add_rst, in_ready}), 64'(2'b10));
      step();
      chk("release_edge2_in_ready", 64'({add_rst, in_ready}), 64'(2'b01));

      // table-driven single operations
      for (int i = 0; i < 4; i++) begin
         issue_wait(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].tag, lat);
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT + 2));
         chk($sformatf("vec%0d_z", i), 64'(out_z), 64'(vecs[i].exp_z));
         chk($sformatf("vec%0d_flags", i), 64'(out_flags), 64'(vecs[i].exp_flags));
         chk($sformatf("vec%0d_tag", i), 64'(out_tag), 64'(vecs[i].tag));
         pop_one(1'b0);
         chk($sformatf("vec%0d_drained", i), 64'(out_valid), 64'(0));
      end

      // sticky flags
      pop_one(1'b1);
      chk("sticky_clear0", 64'(sticky_flags), 64'(0));
      issue_wait(32'h7F800000, 32'h7F800000, 1'b1, 4'd1, lat);
      chk("inv_flag", 64'(out_flags[1]), 64'(1));
      pop_one(1'b0);
      chk("sticky_inv", 64'(sticky_flags), 64'(5'b00010));
      sticky_clr = 1'b1; step(); sticky_clr = 1'b0;
      chk("sticky_clr_nopop", 64'(sticky_flags), 64'(0));
      issue_wait(32'h7F800000, 32'h7F800000, 1'b1, 4'd2, lat);
      pop_one(1'b0);
      issue_wait(32'h00000011, 32'h00000000, 1'b0, 4'd3, lat);
      pop_one(1'b1);
      chk("sticky_clr_with_pop", 64'(sticky_flags), 64'(5'b10001));

      // back-pressure: 20 offered, 16 credits
      idx = 0; fires = 0; pops = 0;
      for (int t = 0; t < 40; t++) begin
         in_valid = (idx < 20);
         in_a = 32'h10000000 + idx; in_b = idx * 3; in_sub = idx[0]; in_tag = idx[TAG_W-1:0];
         fired = in_valid && in_ready;
         step();
         if (fired) begin idx++; fires++; end
      end
      chk("bp_fires", 64'(fires), 64'(16));
      chk("bp_in_ready_low", 64'(in_ready), 64'(0));
      out_ready = 1'b1;
      n = 0;
      while ((idx < 20 || out_valid || sb.size() != 0) && n < 200) begin
         in_valid = (idx < 20);
         in_a = 32'h10000000 + idx; in_b = idx * 3; in_sub = idx[0]; in_tag = idx[TAG_W-1:0];
         fired = in_valid && in_ready;
         if (out_valid) pops++;
         step();
         if (fired) idx++;
         n++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("bp_accepted", 64'(idx), 64'(20));
      chk("bp_popped", 64'(pops), 64'(20));

      // reset mid-flight with one result already queued
      issue_wait(32'h12345678, 32'h00000001, 1'b0, 4'd7, lat);
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_a = 32'hA0000000 + i; in_b = 32'h5; in_sub = 1'b1; in_tag = 4'(i);
         step();
         if (i == 3) begin
            rst = 1'b0;
            in_valid = 1'b0;
            #1;
            break;
         end
      end
      chk("midrst_out_valid", 64'(out_valid), 64'(0));
      chk("midrst_outputs", 64'({out_z, out_flags, out_tag}), 64'(0));
      chk("midrst_add_ops", 64'({add_a, add_b, add_ctrl}), 64'(0));
      chk("midrst_ready_addrst", 64'({add_rst, in_ready}), 64'(2'b10));
      step();
      rst = 1'b1;
      step();
      chk("midrst_edge1", 64'(in_ready), 64'(0));
      step();
      chk("midrst_edge2", 64'(in_ready), 64'(1));
      out_ready = 1'b1;
      n = 0;
      for (int t = 0; t < 40; t++) begin
         if (out_valid) n++;
         step();
      end
      chk("midrst_no_stale", 64'(n), 64'(0));

      // full rate random
      drops = 0; pops = 0;
      for (int i = 0; i < 100; i++) begin
         in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom_range(0, 1));
         in_tag = 4'($urandom_range(0, 15));
         if (!in_ready) drops++;
         if (out_valid) pops++;
         step();
      end
      in_valid = 1'b0;
      n = 0;
      while ((out_valid || sb.size() != 0) && n < 60) begin
         if (out_valid) pops++;
         step(); n++;
      end
      chk("full_rate_no_drop", 64'(drops), 64'(0));
      chk("full_rate_returned", 64'(pops), 64'(100));
      r = fp_model(32'h0, 32'h0, 1'b0);
      chk("idle_after_drain", 64'({out_valid, out_z}), 64'({1'b0, r[36:5]}));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
